// File: rtl/sdram_arbiter.sv
// Three-port round-robin arbiter in front of a single-transaction SDRAM controller.
// Optional WAIT-state timeout abort is compiled in with `define SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  req_valid,
  input  logic [2:0]  req_we,
  input  logic [71:0] req_addr,
  input  logic [47:0] req_wdata,
  output logic [2:0]  req_ack,
  output logic [2:0]  rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  output logic [23:0] mem_address,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out,
  input  logic        mem_ready
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_tmo
    $error("sdram_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
  } req_t;

  logic [2:0][23:0] addr_a;
  logic [2:0][15:0] wdata_a;
  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  state_t      state, state_nxt;
  req_t        cur, cur_d;
  logic [1:0]  win, win_d, last_win, last_win_d, win_nxt, idx;
  logic        any_req, found, done, tmo, rsp_pend, rsp_pend_d;
  logic [2:0]  ack_d, rsp_valid_d;
  logic        wr_d, rd_d, busy_d;
  logic [15:0] rdata_d;

  // The captured request drives the memory bus directly, so it stays stable through WAIT.
  assign mem_address = cur.addr;
  assign mem_data_in = cur.wdata;
  assign any_req     = |req_valid;
  assign done        = (state == WAIT) && (mem_ready || tmo);

  // Round-robin search starting just after the last completed winner.
  always_comb begin
    win_nxt = last_win;
    idx     = last_win;
    found   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (!found && req_valid[idx]) begin
        win_nxt = idx;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cur_d       = cur;
    win_d       = win;
    last_win_d  = last_win;
    ack_d       = '0;
    wr_d        = 1'b0;
    rd_d        = 1'b0;
    rdata_d     = rsp_rdata;
    rsp_pend_d  = 1'b0;
    rsp_valid_d = rsp_pend ? (3'b001 << last_win) : 3'b000;
    busy_d      = (state_nxt != IDLE);
    case (state)
      IDLE: if (any_req) begin
        win_d = win_nxt;
        cur_d = '{we: req_we[win_nxt], addr: addr_a[win_nxt], wdata: wdata_a[win_nxt]};
      end
      ISSUE: begin
        ack_d = 3'b001 << win;
        wr_d  = cur.we;
        rd_d  = !cur.we;
      end
      WAIT: if (done) begin
        rdata_d    = (cur.we || tmo) ? 16'h0 : mem_data_out;
        last_win_d = win;
        rsp_pend_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur       <= '0;
      win       <= 2'd0;
      last_win  <= 2'd2;
      rsp_pend  <= 1'b0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
      mem_wr_en <= 1'b0;
      mem_rd_en <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_d;
      win       <= win_d;
      last_win  <= last_win_d;
      rsp_pend  <= rsp_pend_d;
      req_ack   <= ack_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rdata_d;
      busy      <= busy_d;
      mem_wr_en <= wr_d;
      mem_rd_en <= rd_d;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       err_d;

  // wait_cnt holds the number of WAIT cycles already elapsed before the current one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   wait_cnt <= '0;
    else if (state == WAIT && !done) wait_cnt <= wait_cnt + 8'd1;
    else                            wait_cnt <= '0;
  end

  assign tmo   = (state == WAIT) && !mem_ready && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign err_d = done ? tmo : rsp_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rsp_err <= 1'b0;
    else          rsp_err <= err_d;
  end
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: vector table of single transactions plus
// hand-written round-robin, back-to-back, reset-in-WAIT and timeout sequences.
module tb_sdram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req_valid, req_we;
  logic [71:0] req_addr;
  logic [47:0] req_wdata;
  logic [2:0]  req_ack, rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err, busy, mem_wr_en, mem_rd_en;
  logic [23:0] mem_address;
  logic [15:0] mem_data_in, mem_data_out;
  logic        mem_ready;

  sdram_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          port;
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    int          dly;     // WAIT cycles before mem_ready
    logic [15:0] rdin;    // mem_data_out presented with mem_ready
    logic [15:0] exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int dec(input logic [2:0] oh);
    case (oh)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 3;
    endcase
  endfunction

  task automatic run_txn(input vec_t v);
    logic [2:0] oh;
    oh = 3'b001 << v.port;
    req_valid[v.port] = 1'b1;
    req_we[v.port]    = v.we;
    req_addr[24*v.port +: 24]  = v.addr;
    req_wdata[16*v.port +: 16] = v.wdata;
    mem_ready    = 1'b1;        // stray ready in IDLE/ISSUE
    mem_data_out = 16'hDEAD;
    step();
    chk("ack_early", {29'd0, req_ack}, 32'd0);
    chk("busy_issue", {31'd0, busy}, 32'd1);
    step();
    chk("ack", {29'd0, req_ack}, {29'd0, oh});
    chk("wr_en", {31'd0, mem_wr_en}, {31'd0, v.we});
    chk("rd_en", {31'd0, mem_rd_en}, {31'd0, !v.we});
    chk("addr", {8'd0, mem_address}, {8'd0, v.addr});
    chk("wdata", {16'd0, mem_data_in}, {16'd0, v.wdata});
    req_valid[v.port] = 1'b0;
    req_addr[24*v.port +: 24]  = ~v.addr;
    req_wdata[16*v.port +: 16] = ~v.wdata;
    mem_ready = 1'b0;
    for (int d = 0; d < v.dly; d++) begin
      step();
      chk("strobe_wait", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
      chk("addr_stable", {8'd0, mem_address}, {8'd0, v.addr});
      chk("data_stable", {16'd0, mem_data_in}, {16'd0, v.wdata});
      chk("rsp_wait", {29'd0, rsp_valid}, 32'd0);
    end
    mem_ready    = 1'b1;
    mem_data_out = v.rdin;
    step();
    mem_ready    = 1'b0;
    mem_data_out = 16'hDEAD;
    chk("strobe_off", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    chk("rsp_early", {29'd0, rsp_valid}, 32'd0);
    step();
    chk("rsp_valid", {29'd0, rsp_valid}, {29'd0, oh});
    chk("rdata", {16'd0, rsp_rdata}, {16'd0, v.exp_rd});
    chk("err", {31'd0, rsp_err}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    step();
    chk("rsp_pulse", {29'd0, rsp_valid}, 32'd0);
    chk("rdata_hold", {16'd0, rsp_rdata}, {16'd0, v.exp_rd});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   order[6];
    int   exp_order[6];
    int   n, hit, found_c;
    logic [2:0]  rv_cap;
    logic        err_cap;
    logic [15:0] rd_cap;

    vt[0] = '{1, 1'b1, 24'h000010, 16'hBEEF, 0, 16'h1234, 16'h0000};
    vt[1] = '{1, 1'b0, 24'h000010, 16'h0000, 0, 16'hBEEF, 16'hBEEF};
    vt[2] = '{0, 1'b1, 24'hABCDEF, 16'h5A5A, 5, 16'h7777, 16'h0000};
    vt[3] = '{2, 1'b0, 24'h123456, 16'h0000, 5, 16'hC3C3, 16'hC3C3};
    vt[4] = '{0, 1'b0, 24'hFFFFFF, 16'hFFFF, 2, 16'h8001, 16'h8001};
    exp_order = '{0, 1, 2, 0, 1, 2};

    reset_n = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_data_out = '0; mem_ready = 1'b0;
    step(); step();
    chk("reset_outs", {req_ack, rsp_valid, rsp_rdata, rsp_err, busy, mem_wr_en, mem_rd_en}, 32'd0);
    chk("reset_addr", {8'd0, mem_address}, 32'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_txn(vt[i]);

    // Round-robin from reset with all ports held.
    reset_n = 1'b0; step(); reset_n = 1'b1;
    req_valid = 3'b111; req_we = 3'b000; mem_data_out = 16'h1111;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      step();
      if (req_ack != 3'b000) begin
        order[n] = dec(req_ack);
        n++;
      end
      mem_ready = mem_wr_en | mem_rd_en;
    end
    chk("rr_count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), order[i], exp_order[i]);
    req_valid = 3'b000;
    for (int c = 0; c < 4; c++) begin step(); mem_ready = mem_wr_en | mem_rd_en; end
    mem_ready = 1'b0;

    // Single requester held: granted back-to-back.
    req_valid = 3'b100;
    n = 0; hit = 0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      step();
      if (req_ack == 3'b100) n++;
      else if (req_ack != 3'b000) hit++;
      mem_ready = mem_wr_en | mem_rd_en;
    end
    chk("b2b_grants", n, 2);
    chk("b2b_other", hit, 0);
    req_valid = 3'b000;
    for (int c = 0; c < 4; c++) begin step(); mem_ready = mem_wr_en | mem_rd_en; end
    mem_ready = 1'b0;

    // Reset while in WAIT.
    req_valid = 3'b010;
    step(); step();
    chk("rst_pre_ack", {29'd0, req_ack}, 32'd2);
    req_valid = 3'b000;
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wait_outs", {req_ack, rsp_valid, rsp_rdata, rsp_err, busy, mem_wr_en, mem_rd_en}, 32'd0);
    chk("rst_wait_addr", {8'd0, mem_address}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    mem_ready = 1'b1;
    hit = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (rsp_valid != 3'b000 || mem_wr_en || mem_rd_en) hit++;
    end
    chk("rst_no_rsp", hit, 0);
    mem_ready = 1'b0; req_valid = 3'b111; mem_data_out = 16'h4242;
    step(); step();
    chk("rst_port0_wins", {29'd0, req_ack}, 32'd1);
    req_valid = 3'b000; mem_ready = 1'b1;
    step(); mem_ready = 1'b0;
    step();
    chk("rst_port0_rsp", {29'd0, rsp_valid}, 32'd1);
    step();

`ifdef SDRAM_ARB_TIMEOUT_EN
    req_valid = 3'b010; req_we = 3'b000; mem_ready = 1'b0;
    found_c = -1; rv_cap = '0; err_cap = 1'b0; rd_cap = 16'hFFFF;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (req_ack != 3'b000) req_valid = 3'b000;
      if (rsp_valid != 3'b000 && found_c < 0) begin
        found_c = c; rv_cap = rsp_valid; err_cap = rsp_err; rd_cap = rsp_rdata;
      end
    end
    chk("tmo_cycle", found_c, 7);
    chk("tmo_rsp_valid", {29'd0, rv_cap}, 32'd2);
    chk("tmo_err", {31'd0, err_cap}, 32'd1);
    chk("tmo_rdata", {16'd0, rd_cap}, 32'd0);
    mem_ready = 1'b1; hit = 0;
    for (int c = 0; c < 3; c++) begin step(); if (rsp_valid != 3'b000) hit++; end
    mem_ready = 1'b0;
    chk("tmo_stray_ready", hit, 0);
    run_txn(vt[1]);
`else
    req_valid = 3'b010; req_we = 3'b000; mem_ready = 1'b0;
    hit = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (req_ack != 3'b000) req_valid = 3'b000;
      if (rsp_valid != 3'b000) hit++;
    end
    chk("nto_no_rsp", hit, 0);
    chk("nto_busy", {31'd0, busy}, 32'd1);
    chk("nto_err", {31'd0, rsp_err}, 32'd0);
    mem_ready = 1'b1; mem_data_out = 16'h4321;
    step(); mem_ready = 1'b0;
    step();
    chk("nto_rsp_valid", {29'd0, rsp_valid}, 32'd2);
    chk("nto_rdata", {16'd0, rsp_rdata}, 32'h4321);
    step();
    found_c = 0; rv_cap = '0; err_cap = 1'b0; rd_cap = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
